// File: rtl/prime_index_search.sv
// -----------------------------------------------------------------------------
// prime_index_search
//
// Purpose:
//    Reverse lookup into the table of all 54 primes below 256. Given an 8-bit
//    candidate, a linear scan (one table entry per clock) reports whether the
//    value is prime and where it sits in the table. The key-exchange path uses
//    this to validate a received prime and recover the index the peer drew.
//
// Ports:
//    clk        in   1      system clock, rising edge
//    rst        in   1      synchronous reset, active-high
//    start      in   1      search request, honoured only while idle
//    value      in   8      candidate, captured on the accepted start edge
//    busy       out  1      high while a search is running
//    rdy        out  1      one-cycle pulse marking a valid result
//    found      out  1      candidate is in the table (prime)
//    index_out  out  IDX_W  match index, or insertion point when not found
//                           (N_PRIMES when the value is beyond the last entry)
// -----------------------------------------------------------------------------
module prime_index_search #(
   parameter int N_PRIMES = 54,
   parameter int IDX_W    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       value,
   output logic             busy,
   output logic             rdy,
   output logic             found,
   output logic [IDX_W-1:0] index_out
);

   typedef enum logic {
      IDLE,
      SEARCH
   } state_t;

   localparam logic [IDX_W-1:0] LAST_PTR   = IDX_W'(N_PRIMES - 1);
   localparam logic [IDX_W-1:0] BEYOND_IDX = IDX_W'(N_PRIMES);

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [7:0]       value_q;
   logic [7:0]       entry;

   // Constant ROM of the primes below 256 in ascending order. The scan relies
   // on the ordering to stop as soon as an entry exceeds the candidate.
   function automatic logic [7:0] prime_at(input logic [IDX_W-1:0] i);
      case (i)
         6'd0:  prime_at = 8'd2;
         6'd1:  prime_at = 8'd3;
         6'd2:  prime_at = 8'd5;
         6'd3:  prime_at = 8'd7;
         6'd4:  prime_at = 8'd11;
         6'd5:  prime_at = 8'd13;
         6'd6:  prime_at = 8'd17;
         6'd7:  prime_at = 8'd19;
         6'd8:  prime_at = 8'd23;
         6'd9:  prime_at = 8'd29;
         6'd10: prime_at = 8'd31;
         6'd11: prime_at = 8'd37;
         6'd12: prime_at = 8'd41;
         6'd13: prime_at = 8'd43;
         6'd14: prime_at = 8'd47;
         6'd15: prime_at = 8'd53;
         6'd16: prime_at = 8'd59;
         6'd17: prime_at = 8'd61;
         6'd18: prime_at = 8'd67;
         6'd19: prime_at = 8'd71;
         6'd20: prime_at = 8'd73;
         6'd21: prime_at = 8'd79;
         6'd22: prime_at = 8'd83;
         6'd23: prime_at = 8'd89;
         6'd24: prime_at = 8'd97;
         6'd25: prime_at = 8'd101;
         6'd26: prime_at = 8'd103;
         6'd27: prime_at = 8'd107;
         6'd28: prime_at = 8'd109;
         6'd29: prime_at = 8'd113;
         6'd30: prime_at = 8'd127;
         6'd31: prime_at = 8'd131;
         6'd32: prime_at = 8'd137;
         6'd33: prime_at = 8'd139;
         6'd34: prime_at = 8'd149;
         6'd35: prime_at = 8'd151;
         6'd36: prime_at = 8'd157;
         6'd37: prime_at = 8'd163;
         6'd38: prime_at = 8'd167;
         6'd39: prime_at = 8'd173;
         6'd40: prime_at = 8'd179;
         6'd41: prime_at = 8'd181;
         6'd42: prime_at = 8'd191;
         6'd43: prime_at = 8'd193;
         6'd44: prime_at = 8'd197;
         6'd45: prime_at = 8'd199;
         6'd46: prime_at = 8'd211;
         6'd47: prime_at = 8'd223;
         6'd48: prime_at = 8'd227;
         6'd49: prime_at = 8'd229;
         6'd50: prime_at = 8'd233;
         6'd51: prime_at = 8'd239;
         6'd52: prime_at = 8'd241;
         6'd53: prime_at = 8'd251;
         default: prime_at = 8'd0;
      endcase
   endfunction

   // The pointer never moves past the last entry, so the ROM is only ever
   // read at valid positions.
   assign entry = prime_at(ptr);

   // Search controller. Results are registered and held until the next
   // accepted start clears them; rdy defaults low so it can only pulse for
   // the single cycle following the deciding comparison.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         rdy       <= 1'b0;
         found     <= 1'b0;
         index_out <= '0;
         ptr       <= '0;
         value_q   <= '0;
      end else begin
         rdy <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  value_q   <= value;
                  ptr       <= '0;
                  busy      <= 1'b1;
                  found     <= 1'b0;
                  index_out <= '0;
                  state     <= SEARCH;
               end
            end
            SEARCH: begin
               if (entry == value_q) begin
                  found     <= 1'b1;
                  index_out <= ptr;
                  rdy       <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (entry > value_q) begin
                  // Passed the candidate: ptr is its insertion point.
                  found     <= 1'b0;
                  index_out <= ptr;
                  rdy       <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (ptr == LAST_PTR) begin
                  // Larger than every entry in the table.
                  found     <= 1'b0;
                  index_out <= BEYOND_IDX;
                  rdy       <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
